vga_timing_gen: RTL and testbench

- Generates VGA raster timing: horizontal/vertical pixel counters, sync pulses, and the `bright` (active-video) qualifier.
- Feeds the pixel bit generator, which consumes `bright`, `hCount` and `vCount` and returns RGB.
- Runs from the 50 MHz system clock. An internal pixel-enable divider produces the 25 MHz pixel rate, so the default is 640x480 at 60 Hz.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_pix_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing constants and helpers
// Purpose: default raster timing, derived totals and sync/blank boundaries,
//          shared by the timing generator, bit generator and framebuffer reader.
// Ports:   none (package).
package vga_pkg;

  localparam int COUNT_W = 10;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_BLANK_START = H_VISIBLE;
  localparam int H_SYNC_START  = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END    = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_BLANK_START = V_VISIBLE;
  localparam int V_SYNC_START  = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END    = V_VISIBLE + V_FRONT + V_SYNC;

  // Level driven on a sync line: the asserted level when active, else its inverse.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between generator and pixel consumers
// Purpose: carries counters, syncs and strobes from the timing generator.
// Ports:   master = timing generator (drives all), slave = consumer (reads all).
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   hSync;
  logic   vSync;
  logic   bright;
  count_t hCount;
  count_t vCount;
  logic   pix_en;
  logic   line_start;
  logic   frame_start;

  modport master (
    output hSync, vSync, bright, hCount, vCount, pix_en, line_start, frame_start
  );

  modport slave (
    input hSync, vSync, bright, hCount, vCount, pix_en, line_start, frame_start
  );

endinterface

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - pixel clock-enable divider
// Purpose: counts 0..CLK_DIV-1 and raises pix_en (registered) for the clk in
//          which the count sits at CLK_DIV-1.
// Ports:   clk, rst_n (async active-low), pix_en (one-clk strobe per pixel).
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // pix_en is registered from the next divider value so it is high exactly
  // while div_q == CLK_DIV-1; with CLK_DIV=1 it stays high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      pix_en <= 1'b0;
    end else begin
      div_q  <= div_d;
      pix_en <= (div_d == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator
// Purpose: horizontal/vertical counters, sync pulses, bright qualifier and
//          line/frame start strobes, advancing once per pixel enable.
// Ports:   clk (system clock), rst_n (async active-low, release synchronised
//          here), vga (master modport: hSync, vSync, bright, hCount, vCount,
//          pix_en, line_start, frame_start).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter int SYNC_POL  = 0
) (
  input  logic clk,
  input  logic rst_n,
  vga_timing_gen_if.master vga
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam count_t H_LAST   = count_t'(HT - 1);
  localparam count_t V_LAST   = count_t'(VT - 1);
  localparam count_t H_VIS    = count_t'(H_VISIBLE);
  localparam count_t V_VIS    = count_t'(V_VISIBLE);
  localparam count_t HS_START = count_t'(H_VISIBLE + H_FRONT);
  localparam count_t HS_END   = count_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam count_t VS_START = count_t'(V_VISIBLE + V_FRONT);
  localparam count_t VS_END   = count_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic   POL      = (SYNC_POL != 0);

  // Assertion is immediate through the async clear; release reaches the
  // timing logic two clks after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  logic pix_en;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .pix_en (pix_en)
  );

  assign vga.pix_en = pix_en;

  count_t h_q, v_q, h_d, v_d;
  logic   h_wrap;
  logic   bright_d, hs_d, vs_d, ls_d, fs_d;

  // Decode from the next counter values so registered outputs change on the
  // same edge as the counters.
  always_comb begin
    h_wrap   = pix_en && (h_q == H_LAST);
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en) h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    bright_d = (h_d < H_VIS) && (v_d < V_VIS);
    hs_d     = sync_level((h_d >= HS_START) && (h_d < HS_END), POL);
    vs_d     = sync_level((v_d >= VS_START) && (v_d < VS_END), POL);
    ls_d     = h_wrap;
    fs_d     = h_wrap && (v_d == '0);
  end

  // Reset parks the counters at the last pixel so the first pix_en wraps
  // cleanly into (0,0) and starts a full frame.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      h_q             <= H_LAST;
      v_q             <= V_LAST;
      vga.bright      <= 1'b0;
      vga.hSync       <= ~POL;
      vga.vSync       <= ~POL;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      h_q             <= h_d;
      v_q             <= v_d;
      vga.bright      <= bright_d;
      vga.hSync       <= hs_d;
      vga.vSync       <= vs_d;
      vga.line_start  <= ls_d;
      vga.frame_start <= fs_d;
    end
  end

  assign vga.hCount = h_q;
  assign vga.vCount = v_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - testbench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #10 clk = ~clk;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();

  // Default 640x480, CLK_DIV=2, active-low syncs.
  vga_timing_gen dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif0)
  );

  // Small raster 16x8, CLK_DIV=1, active-high syncs.
  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif1)
  );

  typedef struct { int h; int b; int hs; } vec0_t;
  typedef struct { int h; int v; int b; int hs; int vs; } vec1_t;

  vec0_t t0[8];
  vec1_t t1[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait0_h(input int h, input int budget, input string nm);
    int n = 0;
    while (int'(vif0.hCount) != h && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(vif0.hCount) != h) chk({nm, "_timeout"}, int'(vif0.hCount), h);
  endtask

  task automatic wait1_hv(input int h, input int v, input int budget, input string nm);
    int n = 0;
    while ((int'(vif1.hCount) != h || int'(vif1.vCount) != v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(vif1.hCount) != h || int'(vif1.vCount) != v)
      chk({nm, "_timeout"}, int'(vif1.hCount), h);
  endtask

  task automatic wait_fs(input bit which, input int budget, input string nm);
    int n = 0;
    while (((which ? vif1.frame_start : vif0.frame_start) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((which ? vif1.frame_start : vif0.frame_start) !== 1'b1)
      chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_h0"}, int'(vif0.hCount), 799);
    chk({nm, "_v0"}, int'(vif0.vCount), 524);
    chk({nm, "_b0"}, int'(vif0.bright), 0);
    chk({nm, "_hs0"}, int'(vif0.hSync), 1);
    chk({nm, "_vs0"}, int'(vif0.vSync), 1);
    chk({nm, "_pe0"}, int'(vif0.pix_en), 0);
    chk({nm, "_ls0"}, int'(vif0.line_start), 0);
    chk({nm, "_fs0"}, int'(vif0.frame_start), 0);
    chk({nm, "_h1"}, int'(vif1.hCount), 15);
    chk({nm, "_v1"}, int'(vif1.vCount), 7);
    chk({nm, "_hs1"}, int'(vif1.hSync), 0);
    chk({nm, "_vs1"}, int'(vif1.vSync), 0);
  endtask

  initial begin
    int cnt_b, cnt_hs, cnt_ls, cnt_fs, cnt_pe, cnt_vs, maxh, maxv, n;

    t0[0] = '{0, 1, 1};   t0[1] = '{639, 1, 1}; t0[2] = '{640, 0, 1};
    t0[3] = '{655, 0, 1}; t0[4] = '{656, 0, 0}; t0[5] = '{751, 0, 0};
    t0[6] = '{752, 0, 1}; t0[7] = '{799, 0, 1};

    t1[0] = '{0, 0, 1, 0, 0};  t1[1] = '{7, 3, 1, 0, 0};  t1[2] = '{8, 3, 0, 0, 0};
    t1[3] = '{10, 3, 0, 1, 0}; t1[4] = '{12, 4, 0, 1, 0}; t1[5] = '{13, 4, 0, 0, 0};
    t1[6] = '{0, 5, 0, 0, 1};  t1[7] = '{15, 6, 0, 0, 1}; t1[8] = '{0, 7, 0, 0, 0};

    // Reset held: values must stay parked across several clock edges.
    repeat (5) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // First frame: first advance lands on (0,0) with both strobes.
    wait_fs(1'b0, 20, "first_fs0");
    chk("first_h", int'(vif0.hCount), 0);
    chk("first_v", int'(vif0.vCount), 0);
    chk("first_b", int'(vif0.bright), 1);
    chk("first_ls", int'(vif0.line_start), 1);

    // One full line of dut0 from the frame_start clk.
    cnt_b = 0; cnt_hs = 0; cnt_ls = 0; cnt_fs = 0; cnt_pe = 0;
    for (int i = 0; i < 1600; i++) begin
      cnt_b  += int'(vif0.bright);
      cnt_hs += int'(!vif0.hSync);
      cnt_ls += int'(vif0.line_start);
      cnt_fs += int'(vif0.frame_start);
      cnt_pe += int'(vif0.pix_en);
      @(negedge clk);
    end
    chk("line_bright_clks", cnt_b, 1280);
    chk("line_hsync_clks", cnt_hs, 192);
    chk("line_ls_count", cnt_ls, 1);
    chk("line_fs_count", cnt_fs, 1);
    chk("line_pixen_count", cnt_pe, 800);
    chk("line_period_ls", int'(vif0.line_start), 1);
    chk("line_period_h", int'(vif0.hCount), 0);
    chk("line_period_v", int'(vif0.vCount), 1);
    chk("line_period_fs", int'(vif0.frame_start), 0);

    // Horizontal decode table on dut0 (line 1, visible line).
    for (int i = 0; i < 8; i++) begin
      wait0_h(t0[i].h, 2000, $sformatf("t0_%0d", i));
      chk($sformatf("t0_%0d_bright", i), int'(vif0.bright), t0[i].b);
      chk($sformatf("t0_%0d_hsync", i), int'(vif0.hSync), t0[i].hs);
      chk($sformatf("t0_%0d_vsync", i), int'(vif0.vSync), 1);
    end

    // Raster decode table on dut1 across one frame.
    for (int i = 0; i < 9; i++) begin
      wait1_hv(t1[i].h, t1[i].v, 300, $sformatf("t1_%0d", i));
      chk($sformatf("t1_%0d_bright", i), int'(vif1.bright), t1[i].b);
      chk($sformatf("t1_%0d_hsync", i), int'(vif1.hSync), t1[i].hs);
      chk($sformatf("t1_%0d_vsync", i), int'(vif1.vSync), t1[i].vs);
    end

    // dut1 frame: period, pix_en constant, vsync/bright extents, no overrun.
    wait_fs(1'b1, 300, "fs1");
    cnt_b = 0; cnt_vs = 0; cnt_fs = 0; cnt_pe = 0; maxh = 0; maxv = 0; n = 0;
    do begin
      cnt_b  += int'(vif1.bright);
      cnt_vs += int'(vif1.vSync);
      cnt_fs += int'(vif1.frame_start);
      cnt_pe += int'(!vif1.pix_en);
      if (int'(vif1.hCount) > maxh) maxh = int'(vif1.hCount);
      if (int'(vif1.vCount) > maxv) maxv = int'(vif1.vCount);
      @(negedge clk);
      n++;
    end while (vif1.frame_start !== 1'b1 && n < 400);
    chk("f1_period", n, 128);
    chk("f1_bright_clks", cnt_b, 32);
    chk("f1_vsync_clks", cnt_vs, 32);
    chk("f1_fs_count", cnt_fs, 1);
    chk("f1_pixen_low_clks", cnt_pe, 0);
    chk("f1_max_h", maxh, 15);
    chk("f1_max_v", maxv, 7);

    // Wrap boundaries on dut1.
    wait1_hv(15, 7, 300, "wrap_end");
    @(negedge clk);
    chk("wrap_end_h", int'(vif1.hCount), 0);
    chk("wrap_end_v", int'(vif1.vCount), 0);
    wait1_hv(15, 2, 300, "wrap_mid");
    @(negedge clk);
    chk("wrap_mid_h", int'(vif1.hCount), 0);
    chk("wrap_mid_v", int'(vif1.vCount), 3);

    // Mid-line reset on dut0: immediate, no clock edge needed.
    wait0_h(300, 2000, "mid");
    #5 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_fs(1'b0, 20, "resume_fs0");
    chk("resume_h", int'(vif0.hCount), 0);
    chk("resume_v", int'(vif0.vCount), 0);
    chk("resume_b", int'(vif0.bright), 1);
    chk("resume_ls", int'(vif0.line_start), 1);
    @(negedge clk);
    chk("resume_fs_width", int'(vif0.frame_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
